// File: rtl/ssd_decoder.sv
// ssd_decoder: recovers a 16-bit word from a multiplexed four-digit
// seven-segment display scan. Pins are synchronized, each digit must hold
// steady for STABLE_CYCLES samples before it is captured, and a frame is
// published once all four digit positions have been captured.
module ssd_decoder #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 262144
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SEN1,
  input  logic        SEN2,
  input  logic        SEN3,
  input  logic        SEN4,
  input  logic        SSA,
  input  logic        SSB,
  input  logic        SSC,
  input  logic        SSD,
  input  logic        SSE,
  input  logic        SSF,
  input  logic        SSG,
  output logic [15:0] WORD,
  output logic        VALID,
  output logic        ERR,
  output logic        STALL
);

  // Counter value seen on the cycle before the STABLE_CYCLES-th identical
  // sample; the acceptance edge moves it to STABLE_CYCLES-1.
  localparam logic [7:0]  ACCEPT_AT = 8'(STABLE_CYCLES - 2);
  localparam int unsigned IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Input synchronization
  // Bit layout: [10:7] = {SEN1, SEN2, SEN3, SEN4}, [6:0] = {SSA..SSG}.
  // ---------------------------------------------------------------------
  logic [10:0] pins;
  logic [10:0] sync1_reg;
  logic [10:0] sync2_reg;

  assign pins = {SEN1, SEN2, SEN3, SEN4, SSA, SSB, SSC, SSD, SSE, SSF, SSG};

  // Two-flop synchronizer on every pin input
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= pins;
      sync2_reg <= sync1_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Sample classification and segment decode
  // ---------------------------------------------------------------------
  logic [3:0] sel_hot;     // bit i high selects WORD[4*i+3 : 4*i]
  logic [6:0] seg_code;
  logic       is_sel;
  logic [3:0] seg_nib;
  logic       seg_bad;

  assign sel_hot  = ~sync2_reg[10:7];
  assign seg_code = sync2_reg[6:0];
  // Exactly one enable low; none or several low is a blank sample
  assign is_sel   = (sel_hot != 4'b0000) && ((sel_hot & (sel_hot - 4'd1)) == 4'b0000);

  // Segment code to nibble; unknown codes flag the digit as invalid
  always_comb begin
    seg_nib = 4'h0;
    seg_bad = 1'b0;
    case (seg_code)
      7'h7E: seg_nib = 4'h0;
      7'h30: seg_nib = 4'h1;
      7'h6D: seg_nib = 4'h2;
      7'h79: seg_nib = 4'h3;
      7'h33: seg_nib = 4'h4;
      7'h5B: seg_nib = 4'h5;
      7'h5F: seg_nib = 4'h6;
      7'h70: seg_nib = 4'h7;
      7'h7F: seg_nib = 4'h8;
      7'h7B: seg_nib = 4'h9;
      7'h77: seg_nib = 4'hA;
      7'h1F: seg_nib = 4'hB;
      7'h4E: seg_nib = 4'hC;
      7'h3D: seg_nib = 4'hD;
      7'h6F: seg_nib = 4'hE;
      7'h47: seg_nib = 4'hF;
      default: seg_bad = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Stability tracking and acceptance
  // ---------------------------------------------------------------------
  logic [10:0] prev_reg;
  logic [10:0] last_acc_reg;
  logic [7:0]  stab_cnt_reg;
  logic        first_reg;
  logic        armed_reg;
  logic        changed;
  logic        accept;

  // The very first sample after reset counts as a change.
  assign changed = first_reg || (sync2_reg != prev_reg);

  // A stable run is captured once. A short glitch followed by the original
  // code is not a new digit: only a blank, or a sample that differs from
  // the last captured one, allows another capture.
  assign accept = is_sel && !changed && (stab_cnt_reg == ACCEPT_AT) &&
                  (armed_reg || (sync2_reg != last_acc_reg));

  // Saturating stability counter plus acceptance arming
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_reg     <= '0;
      last_acc_reg <= '0;
      stab_cnt_reg <= '0;
      first_reg    <= 1'b1;
      armed_reg    <= 1'b1;
    end else begin
      first_reg <= 1'b0;
      prev_reg  <= sync2_reg;
      if (!is_sel || changed) begin
        stab_cnt_reg <= '0;
      end else if (stab_cnt_reg != 8'hFF) begin
        stab_cnt_reg <= stab_cnt_reg + 8'd1;
      end
      if (!is_sel) begin
        armed_reg <= 1'b1;
      end else if (accept) begin
        armed_reg    <= 1'b0;
        last_acc_reg <= sync2_reg;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Idle timeout
  // ---------------------------------------------------------------------
  logic [IDLE_W-1:0] idle_cnt_reg;
  logic              timeout_hit;

  // Acceptance wins over a timeout landing in the same cycle.
  assign timeout_hit = !accept && (idle_cnt_reg == IDLE_LAST);

  // Idle counter with hold at the limit; STALL tracks the expired state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idle_cnt_reg <= '0;
      STALL        <= 1'b0;
    end else if (accept) begin
      idle_cnt_reg <= '0;
      STALL        <= 1'b0;
    end else if (idle_cnt_reg != IDLE_MAX) begin
      idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
      if (timeout_hit) begin
        STALL <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame buffer: one nibble, invalid mark and capture bit per digit
  // ---------------------------------------------------------------------
  logic [3:0]  mask_vec;
  logic [3:0]  inv_vec;
  logic [15:0] frame_vec;
  logic        complete;

  assign complete = (mask_vec == 4'hF);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic       dig_mask_reg;
      logic       dig_inv_reg;
      logic [3:0] dig_nib_reg;

      // Capture this digit on acceptance; drop the mark on frame end or timeout
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          dig_mask_reg <= 1'b0;
          dig_inv_reg  <= 1'b0;
          dig_nib_reg  <= 4'h0;
        end else if (complete) begin
          dig_mask_reg <= 1'b0;
          dig_inv_reg  <= 1'b0;
        end else if (accept && sel_hot[gi]) begin
          dig_mask_reg <= 1'b1;
          dig_inv_reg  <= seg_bad;
          dig_nib_reg  <= seg_nib;
        end else if (timeout_hit) begin
          dig_mask_reg <= 1'b0;
          dig_inv_reg  <= 1'b0;
        end
      end

      assign mask_vec[gi]           = dig_mask_reg;
      assign inv_vec[gi]            = dig_inv_reg;
      assign frame_vec[4*gi +: 4]   = dig_nib_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Frame publication
  // ---------------------------------------------------------------------
  // One cycle after the fourth capture: publish a clean frame or flag a bad one
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      WORD  <= 16'h0000;
      VALID <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      VALID <= 1'b0;
      ERR   <= 1'b0;
      if (complete) begin
        if (inv_vec == 4'h0) begin
          WORD  <= frame_vec;
          VALID <= 1'b1;
        end else begin
          ERR <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_decoder.sv
// tb_ssd_decoder: directed scans of the seven-segment decoder with
// hand-computed expected words, pulse counts and latency.
module tb_ssd_decoder;

  localparam int STABLE  = 16;
  localparam int TIMEOUT = 2000;
  localparam int DWELL   = 64;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        SEN1 = 1'b1, SEN2 = 1'b1, SEN3 = 1'b1, SEN4 = 1'b1;
  logic        SSA = 1'b0, SSB = 1'b0, SSC = 1'b0, SSD = 1'b0;
  logic        SSE = 1'b0, SSF = 1'b0, SSG = 1'b0;
  logic [15:0] WORD;
  logic        VALID, ERR, STALL;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int valid_cnt  = 0;
  int err_cnt    = 0;
  int both_cnt   = 0;
  int cyc        = 0;
  int valid_cyc  = 0;
  int drive_cyc  = 0;
  int v0, e0;

  ssd_decoder #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .SEN1 (SEN1),
    .SEN2 (SEN2),
    .SEN3 (SEN3),
    .SEN4 (SEN4),
    .SSA  (SSA),
    .SSB  (SSB),
    .SSC  (SSC),
    .SSD  (SSD),
    .SSE  (SSE),
    .SSF  (SSF),
    .SSG  (SSG),
    .WORD (WORD),
    .VALID(VALID),
    .ERR  (ERR),
    .STALL(STALL)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge
  always @(negedge CLK) begin
    if (VALID) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
    end
    if (ERR) err_cnt <= err_cnt + 1;
    if (VALID && ERR) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'h0: c = 7'h7E;  4'h1: c = 7'h30;  4'h2: c = 7'h6D;  4'h3: c = 7'h79;
      4'h4: c = 7'h33;  4'h5: c = 7'h5B;  4'h6: c = 7'h5F;  4'h7: c = 7'h70;
      4'h8: c = 7'h7F;  4'h9: c = 7'h7B;  4'hA: c = 7'h77;  4'hB: c = 7'h1F;
      4'hC: c = 7'h4E;  4'hD: c = 7'h3D;  4'hE: c = 7'h6F;  default: c = 7'h47;
    endcase
    return c;
  endfunction

  // sen is {SEN1, SEN2, SEN3, SEN4}, active-low
  task automatic drive_raw(input logic [3:0] sen, input logic [6:0] code, input int cycles);
    @(posedge CLK);
    #1;
    {SEN1, SEN2, SEN3, SEN4} = sen;
    {SSA, SSB, SSC, SSD, SSE, SSF, SSG} = code;
    repeat (cycles - 1) @(posedge CLK);
  endtask

  // pos 1..4 selects SENpos
  task automatic drive(input int pos, input logic [6:0] code, input int cycles);
    logic [3:0] sen;
    sen = ~(4'b0001 << (4 - pos));
    @(posedge CLK);
    #1;
    {SEN1, SEN2, SEN3, SEN4} = sen;
    {SSA, SSB, SSC, SSD, SSE, SSF, SSG} = code;
    drive_cyc = cyc;
    repeat (cycles - 1) @(posedge CLK);
  endtask

  task automatic blank(input int cycles);
    drive_raw(4'hF, 7'h00, cycles);
  endtask

  task automatic scan(input logic [15:0] w);
    $display("scan word=%h", w);
    drive(4, seg_of(w[3:0]), DWELL);
    drive(3, seg_of(w[7:4]), DWELL);
    drive(2, seg_of(w[11:8]), DWELL);
    drive(1, seg_of(w[15:12]), DWELL);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_word",  32'(WORD),  32'h0000);
    check("rst_valid", 32'(VALID), 32'h0);
    check("rst_err",   32'(ERR),   32'h0);
    check("rst_stall", 32'(STALL), 32'h0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    blank(4);

    // Clean frame and completing-digit latency
    v0 = valid_cnt; e0 = err_cnt;
    scan(16'hBEEF);
    blank(8);
    check("beef_word",    32'(WORD), 32'hBEEF);
    check("beef_valid",   32'(valid_cnt - v0), 32'd1);
    check("beef_err",     32'(err_cnt - e0), 32'd0);
    check("beef_latency", 32'(valid_cyc - drive_cyc), 32'(2 + STABLE + 1));

    // Undecodable digit on SEN2
    $display("scan 1234 with SEN2 code 00");
    v0 = valid_cnt; e0 = err_cnt;
    drive(4, seg_of(4'h4), DWELL);
    drive(3, seg_of(4'h3), DWELL);
    drive(2, 7'h00, DWELL);
    drive(1, seg_of(4'h1), DWELL);
    blank(8);
    check("bad_err",   32'(err_cnt - e0), 32'd1);
    check("bad_valid", 32'(valid_cnt - v0), 32'd0);
    check("bad_word",  32'(WORD), 32'hBEEF);

    // Re-capture overwrites an invalid digit
    $display("recapture SEN4 invalid then C, frame 1D6C");
    v0 = valid_cnt; e0 = err_cnt;
    drive(4, 7'h00, DWELL);
    drive(3, seg_of(4'h6), DWELL);
    drive(4, seg_of(4'hC), DWELL);
    drive(2, seg_of(4'hD), DWELL);
    drive(1, seg_of(4'h1), DWELL);
    blank(8);
    check("recap_word",  32'(WORD), 32'h1D6C);
    check("recap_valid", 32'(valid_cnt - v0), 32'd1);
    check("recap_err",   32'(err_cnt - e0), 32'd0);

    // Short segment glitches before and after capture
    $display("glitch scan 5A69");
    v0 = valid_cnt; e0 = err_cnt;
    drive(4, seg_of(4'h9), 8);
    drive(4, 7'h00, 5);
    drive(4, seg_of(4'h9), DWELL - 13);
    drive(3, seg_of(4'h6), 30);
    drive(3, seg_of(4'h8), 5);
    drive(3, seg_of(4'h6), DWELL - 35);
    drive(2, seg_of(4'hA), DWELL);
    drive(1, seg_of(4'h5), DWELL);
    blank(8);
    check("glitch_word",  32'(WORD), 32'h5A69);
    check("glitch_valid", 32'(valid_cnt - v0), 32'd1);
    check("glitch_err",   32'(err_cnt - e0), 32'd0);

    // Partial frame then idle timeout
    $display("three digits then idle");
    v0 = valid_cnt; e0 = err_cnt;
    drive(4, seg_of(4'h1), DWELL);
    drive(3, seg_of(4'h2), DWELL);
    drive(2, seg_of(4'h3), DWELL);
    blank(TIMEOUT - 100);
    @(negedge CLK);
    check("stall_before", 32'(STALL), 32'h0);
    blank(110);
    @(negedge CLK);
    check("stall_set",       32'(STALL), 32'h1);
    check("stall_valid",     32'(valid_cnt - v0), 32'd0);
    check("stall_err",       32'(err_cnt - e0), 32'd0);
    v0 = valid_cnt;
    scan(16'h0F0F);
    blank(8);
    @(negedge CLK);
    check("resume_stall", 32'(STALL), 32'h0);
    check("resume_word",  32'(WORD), 32'h0F0F);
    check("resume_valid", 32'(valid_cnt - v0), 32'd1);

    // Reset mid-frame
    $display("two digits then reset");
    drive(4, seg_of(4'h5), DWELL);
    drive(3, seg_of(4'h5), DWELL);
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    {SEN1, SEN2, SEN3, SEN4} = 4'hF;
    repeat (3) @(negedge CLK);
    check("mrst_word",  32'(WORD),  32'h0000);
    check("mrst_valid", 32'(VALID), 32'h0);
    check("mrst_err",   32'(ERR),   32'h0);
    check("mrst_stall", 32'(STALL), 32'h0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    blank(4);
    v0 = valid_cnt; e0 = err_cnt;
    $display("scan A5C3 upper digits first");
    drive(2, seg_of(4'h5), DWELL);
    drive(1, seg_of(4'hA), DWELL);
    blank(8);
    check("mrst_half", 32'(valid_cnt - v0 + err_cnt - e0), 32'd0);
    drive(4, seg_of(4'h3), DWELL);
    drive(3, seg_of(4'hC), DWELL);
    blank(8);
    check("mrst_word2", 32'(WORD), 32'hA5C3);
    check("mrst_valid2", 32'(valid_cnt - v0), 32'd1);

    // Two enables low together is blank
    $display("SEN1+SEN3 low for 100 cycles inside frame 9876");
    v0 = valid_cnt; e0 = err_cnt;
    drive(4, seg_of(4'h6), DWELL);
    drive(3, seg_of(4'h7), DWELL);
    drive(2, seg_of(4'h8), DWELL);
    drive_raw(4'b0101, seg_of(4'h9), 100);
    check("multi_none", 32'(valid_cnt - v0 + err_cnt - e0), 32'd0);
    drive(1, seg_of(4'h9), DWELL);
    blank(8);
    check("multi_word",  32'(WORD), 32'h9876);
    check("multi_valid", 32'(valid_cnt - v0), 32'd1);

    check("valid_err_overlap", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/ssd_decoder.md
SSD_DECODER -- requirements
Module: ssd_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 16, which sets the consecutive identical synchronized samples needed to accept a digit (legal range 2..255).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 262144, which sets the cycles without an accepted digit before the partial frame is discarded.
REQ-003 CLK  input  1  single system clock; all state changes on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 SEN1, SEN2, SEN3, SEN4  input  1 each  digit enables, active-low; SEN1 selects WORD[15:12], SEN2 [11:8], SEN3 [7:4], SEN4 [3:0].
REQ-006 SSA, SSB, SSC, SSD, SSE, SSF, SSG  input  1 each  segment lines, active-high; code = {SSA..SSG}, SSA is MSB.
REQ-007 WORD  output  16  last complete, error-free decoded frame.
REQ-008 VALID  output  1  one-cycle pulse when WORD is updated.
REQ-009 ERR  output  1  one-cycle pulse when a completed frame contained an undecodable digit.
REQ-010 STALL  output  1  level; high while the timeout has expired and no digit has been accepted since.

Function
REQ-011 All 11 pin inputs SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 A sample SHALL be a selection only when exactly one SEN is low; all-high or multiple-low samples are blank.
REQ-013 A blank sample SHALL clear the stability counter and re-arm acceptance.
REQ-014 The stability counter SHALL increment while the {SEN, segment} sample equals the previous cycle's sample, saturating, and SHALL clear on any change.
REQ-015 A digit SHALL be accepted once, on the cycle the counter reaches STABLE_CYCLES-1 (STABLE_CYCLES identical samples), and not again until the sample changes.
REQ-016 Decode table SHALL be 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 77->A, 1F->B, 4E->C, 3D->D, 6F->E, 47->F (hex segment code -> nibble).
REQ-017 Any other code SHALL mark that digit invalid, and the invalid mark SHALL be stored alongside the nibble.
REQ-018 An accepted digit SHALL write its nibble into the frame buffer and set its bit in a 4-bit capture mask.
REQ-019 Re-capture of an already-set digit before frame completion SHALL overwrite the stored nibble and invalid mark.
REQ-020 When the mask becomes 1111 with no invalid mark, the cycle after acceptance SHALL load WORD and pulse VALID, and the mask and marks SHALL clear in that same cycle.
REQ-021 When the mask becomes 1111 with any invalid mark, the cycle after acceptance SHALL pulse ERR, WORD SHALL hold, and the mask and marks SHALL clear.
REQ-022 VALID and ERR SHALL never be high together, and each SHALL be high for exactly one cycle per frame.
REQ-023 End-to-end latency from a stable pin change to VALID SHALL be 2 + STABLE_CYCLES + 1 cycles for the completing digit.
REQ-024 The idle counter SHALL clear on each acceptance.
REQ-025 When the idle counter reaches TIMEOUT_CYCLES, the mask and marks SHALL clear, STALL SHALL set, and the idle counter SHALL hold.
REQ-026 STALL SHALL clear on the next acceptance, and that acceptance SHALL be recorded into the freshly cleared mask.
REQ-027 An acceptance in the same cycle as the timeout SHALL take priority, so the timeout is ignored.

Reset
REQ-028 While RST_N is low, WORD SHALL be 16'h0000; VALID, ERR and STALL SHALL be 0; and the synchronizers, counters, mask, marks and frame buffer SHALL be cleared.
REQ-029 Reset assertion mid-frame SHALL discard the partial frame, and no VALID or ERR SHALL follow reset release until four new digits are accepted.
REQ-030 The first sample after reset release SHALL be treated as a change, so the stability count starts from zero.

Verification
REQ-031 Scan 4 digits of 16'hBEEF, 64 cycles per digit, in SEN4..SEN1 order -> WORD=16'hBEEF, one VALID, no ERR.
REQ-032 Digit SEN2 shows code 00 in frame 16'h1234 -> one ERR pulse, WORD keeps its prior value, no VALID.
REQ-033 Glitch the segment lines for 5 cycles (less than STABLE_CYCLES) mid-dwell -> no extra acceptance, and the frame still decodes correctly.
REQ-034 Scan 3 digits, then stop for TIMEOUT_CYCLES+10 -> STALL=1, no VALID; resume with a full scan of 16'h0F0F -> STALL clears, WORD=16'h0F0F.
REQ-035 Assert RST_N low after 2 digits of a frame -> outputs return to reset values; a subsequent full scan of 16'hA5C3 -> a single VALID with WORD=16'hA5C3.
REQ-036 Drive SEN1 and SEN3 low together for 100 cycles -> no acceptance, and the mask is unchanged.
